c_arb: RTL and testbench

C_ARB -- requirements
Module: c_arb

---
 rtl/c_arb_if.sv | 32 +++
 rtl/c_arb.sv | 92 +++++++++
 tb/tb_c_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c_arb_if.sv
// Request/response bundle for c_arb: N requesters of W-bit vectors, one
// response channel carrying the admission result.
interface c_arb_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(W + 1);

    logic [N-1:0]   i_req_vld;
    logic [N*W-1:0] i_req_x;
    logic [N-1:0]   o_req_rdy;
    logic           o_rsp_vld;
    logic           i_rsp_rdy;
    logic [IW-1:0]  o_rsp_id;
    logic           o_rsp_is_unary;
    logic           o_rsp_is_compliment;
    logic [LW-1:0]  o_rsp_len;
    logic [15:0]    o_rej_cnt;

    modport master (
        output i_req_vld, i_req_x, i_rsp_rdy,
        input  o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_is_unary,
               o_rsp_is_compliment, o_rsp_len, o_rej_cnt
    );

    modport slave (
        input  i_req_vld, i_req_x, i_rsp_rdy,
        output o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_is_unary,
               o_rsp_is_compliment, o_rsp_len, o_rej_cnt
    );
endinterface

// File: rtl/c_arb.sv
// Round-robin arbiter feeding one shared thermometer-code admission evaluator;
// the result is held in a single response register with 1-cycle latency.
module c_arb #(
    parameter int W                     = 8,
    parameter int N                     = 4,
    parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
    input logic   clk,
    input logic   rst,
    c_arb_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(W + 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic          found;
    logic [N-1:0]  gnt;
    logic          acc_en;
    logic          xfer;

    assign acc_en = !bus.o_rsp_vld || bus.i_rsp_rdy;

    // First valid requester at or after ptr, wrapping; gated off during reset.
    always_comb begin
        int k;
        k       = 0;
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && bus.i_req_vld[k]) begin
                found   = 1'b1;
                gnt_idx = IW'(k);
            end
        end
        if (acc_en && found && !rst)
            gnt[gnt_idx] = 1'b1;
    end

    assign bus.o_req_rdy = gnt;
    assign xfer          = |gnt;

    logic [W-1:0]  x_sel;
    logic [W-1:0]  x_norm;
    logic [W:0]    x_inc;
    logic          cmp_form;
    logic          ev_unary;
    logic [LW-1:0] ev_len;

    assign x_sel = bus.i_req_x[int'(gnt_idx)*W +: W];

    // Complemented inputs are folded back to normal form, so a single
    // x & (x+1) == 0 test covers both encodings.
    always_comb begin
        cmp_form = (P_ADMIT_COMPLIMENT_EN != 0) && x_sel[W-1];
        x_norm   = cmp_form ? ~x_sel : x_sel;
        x_inc    = {1'b0, x_norm} + (W+1)'(1);
        ev_unary = ((x_norm & x_inc[W-1:0]) == '0);
        ev_len   = '0;
        for (int i = 0; i < W; i++)
            if (x_norm[i]) ev_len = ev_len + LW'(1);
        if (!ev_unary) begin
            ev_len   = '0;
            cmp_form = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr                     <= '0;
            bus.o_rsp_vld           <= 1'b0;
            bus.o_rsp_id            <= '0;
            bus.o_rsp_is_unary      <= 1'b0;
            bus.o_rsp_is_compliment <= 1'b0;
            bus.o_rsp_len           <= '0;
            bus.o_rej_cnt           <= '0;
        end else if (xfer) begin
            ptr                     <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + IW'(1);
            bus.o_rsp_vld           <= 1'b1;
            bus.o_rsp_id            <= gnt_idx;
            bus.o_rsp_is_unary      <= ev_unary;
            bus.o_rsp_is_compliment <= cmp_form;
            bus.o_rsp_len           <= ev_len;
            if (!ev_unary && bus.o_rej_cnt != 16'hFFFF)
                bus.o_rej_cnt <= bus.o_rej_cnt + 16'd1;
        end else if (bus.i_rsp_rdy) begin
            bus.o_rsp_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_c_arb.sv
// Scenario bench for c_arb (W=8, N=4): grants are predicted by the bench and
// every response is matched against a scoreboard of model results.
module tb_c_arb;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        logic [1:0] id;
        logic       u;
        logic       c;
        logic [3:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    c_arb_if #(.W(W), .N(N)) bus ();

    c_arb #(.W(W), .N(N), .P_ADMIT_COMPLIMENT_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: search all thermometer lengths directly.
    function automatic exp_t model(input int id, input logic [7:0] x);
        exp_t e;
        logic [7:0] y;
        e.id = 2'(id); e.u = 1'b0; e.c = 1'b0; e.len = 4'd0;
        if (x[7]) begin
            y = ~x;
            for (int l = 0; l < 8; l++)
                if (int'(y) == (1 << l) - 1) begin e.u = 1'b1; e.c = 1'b1; e.len = 4'(l); end
        end else begin
            for (int l = 0; l <= 8; l++)
                if (int'(x) == (1 << l) - 1) begin e.u = 1'b1; e.len = 4'(l); end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req_vld = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) q.delete();
            else begin
                if (bus.o_rsp_vld && bus.i_rsp_rdy) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp_unexpected id=%0d", bus.o_rsp_id);
                    end else begin
                        e = q.pop_front();
                        if ({bus.o_rsp_id, bus.o_rsp_is_unary, bus.o_rsp_is_compliment, bus.o_rsp_len}
                            !== {e.id, e.u, e.c, e.len}) begin
                            failures++;
                            $display("FAIL rsp_fields got id=%0d u=%0b c=%0b len=%0d want id=%0d u=%0b c=%0b len=%0d",
                                     bus.o_rsp_id, bus.o_rsp_is_unary, bus.o_rsp_is_compliment, bus.o_rsp_len,
                                     e.id, e.u, e.c, e.len);
                        end
                    end
                end
                for (int k = 0; k < N; k++)
                    if (bus.o_req_rdy[k] && bus.i_req_vld[k])
                        q.push_back(model(k, bus.i_req_x[k*W +: W]));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_req_vld = 4'b1111;
        bus.i_req_x = {4{8'h07}};
        bus.i_rsp_rdy = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (bus.o_req_rdy !== 4'b0000 || bus.o_rsp_vld !== 1'b0 || bus.o_rsp_id !== 2'd0 ||
            bus.o_rsp_is_unary !== 1'b0 || bus.o_rsp_is_compliment !== 1'b0 ||
            bus.o_rsp_len !== 4'd0 || bus.o_rej_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b id=%0d u=%b c=%b len=%0d rej=%0d want all zero",
                     bus.o_req_rdy, bus.o_rsp_vld, bus.o_rsp_id, bus.o_rsp_is_unary,
                     bus.o_rsp_is_compliment, bus.o_rsp_len, bus.o_rej_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.i_rsp_rdy = 1'b1;
        bus.i_req_vld = 4'b0001;
        bus.i_req_x = {24'h0, 8'h07};
        @(negedge clk);
        checks++;
        if (bus.o_req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got %b want 0001", bus.o_req_rdy);
        end
        step();
        bus.i_req_vld = '0;
        @(negedge clk);
        checks++;
        if (bus.o_rsp_vld !== 1'b1 || bus.o_rsp_id !== 2'd0 || bus.o_rsp_is_unary !== 1'b1 ||
            bus.o_rsp_is_compliment !== 1'b0 || bus.o_rsp_len !== 4'd3) begin
            failures++;
            $display("FAIL single_rsp got vld=%b id=%0d u=%b c=%b len=%0d want 1 0 1 0 3",
                     bus.o_rsp_vld, bus.o_rsp_id, bus.o_rsp_is_unary, bus.o_rsp_is_compliment, bus.o_rsp_len);
        end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.i_rsp_rdy = 1'b1;
        bus.i_req_x = {8'h0F, 8'h07, 8'h03, 8'h01};
        bus.i_req_vld = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_req_rdy !== 4'(1 << (i % 4))) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d got %b want %b", i, bus.o_req_rdy, 4'(1 << (i % 4)));
            end
            if (i > 0) begin
                checks++;
                if (bus.o_rsp_vld !== 1'b1) begin
                    failures++;
                    $display("FAIL rr_stream cycle=%0d got vld=%b want 1", i, bus.o_rsp_vld);
                end
            end
            step();
        end
        bus.i_req_vld = '0;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (bus.o_rsp_vld !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain got vld=%b want 0", bus.o_rsp_vld);
        end
    endtask

    task automatic test_codes();
        logic [7:0] v [4];
        v[0] = 8'hF0; v[1] = 8'hFF; v[2] = 8'h00; v[3] = 8'h5A;
        do_reset();
        bus.i_rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_req_vld = 4'b0001;
            bus.i_req_x = {24'h0, v[i]};
            step();
            bus.i_req_vld = '0;
        end
        @(negedge clk);
        checks++;
        if (bus.o_rej_cnt !== 16'd1) begin
            failures++;
            $display("FAIL codes_rej got %0d want 1", bus.o_rej_cnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.i_rsp_rdy = 1'b0;
        bus.i_req_vld = 4'b0001;
        bus.i_req_x = {8'h00, 8'h1F, 8'h00, 8'h03};
        step();
        bus.i_req_vld = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_req_rdy !== 4'b0000 || bus.o_rsp_vld !== 1'b1 || bus.o_rsp_id !== 2'd0 ||
                bus.o_rsp_is_unary !== 1'b1 || bus.o_rsp_is_compliment !== 1'b0 || bus.o_rsp_len !== 4'd2) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got rdy=%b vld=%b id=%0d u=%b c=%b len=%0d want 0000 1 0 1 0 2",
                         i, bus.o_req_rdy, bus.o_rsp_vld, bus.o_rsp_id, bus.o_rsp_is_unary,
                         bus.o_rsp_is_compliment, bus.o_rsp_len);
            end
            step();
        end
        bus.i_rsp_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_req_rdy !== 4'b0100) begin
            failures++;
            $display("FAIL bp_release got %b want 0100", bus.o_req_rdy);
        end
        step();
        bus.i_req_vld = '0;
        step();
    endtask

    task automatic test_rej_saturate();
        int n = 0;
        int cyc = 0;
        do_reset();
        bus.i_rsp_rdy = 1'b1;
        bus.i_req_x = {4{8'h5A}};
        bus.i_req_vld = 4'b1111;
        while (n < 65534 && cyc < 70000) begin
            @(negedge clk);
            if (|bus.o_req_rdy) n++;
            cyc++;
            step();
        end
        bus.i_req_vld = '0;
        @(negedge clk);
        checks++;
        if (n != 65534 || bus.o_rej_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL rej_fffe grants=%0d got %h want fffe", n, bus.o_rej_cnt);
        end
        step();
        bus.i_req_vld = 4'b0001;
        for (int i = 0; i < 3; i++) step();
        bus.i_req_vld = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_rej_cnt !== 16'hFFFF) begin
                failures++;
                $display("FAIL rej_sat got %h want ffff", bus.o_rej_cnt);
            end
            step();
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        bus.i_rsp_rdy = 1'b1;
        bus.i_req_x = {8'h0F, 8'h07, 8'h5A, 8'h03};
        bus.i_req_vld = 4'b0011;
        step();
        step();
        rst = 1'b1;
        bus.i_req_vld = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus.o_req_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL rstp_gate got %b want 0000", bus.o_req_rdy);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_rsp_vld !== 1'b0 || bus.o_rej_cnt !== 16'd0 || bus.o_req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL rstp_after got vld=%b rej=%0d rdy=%b want 0 0 0001",
                     bus.o_rsp_vld, bus.o_rej_cnt, bus.o_req_rdy);
        end
        step();
        bus.i_req_vld = '0;
        step();
        step();
    endtask

    initial begin
        bus.i_req_vld = '0;
        bus.i_req_x = '0;
        bus.i_rsp_rdy = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_codes();
        test_backpressure();
        test_rej_saturate();
        test_reset_pending();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
